// File: rtl/i2c_in_filter.sv
// i2c_in_filter: receive-side conditioner for the I2C slave pads.
// Synchronises and deglitches SCL/SDA, then derives SCL edge strobes,
// START/STOP strobes, a bus-busy flag and a delayed SCL for SDA hold timing.
module i2c_in_filter #(
  parameter int SYNC_STAGES = 2,  // flops per synchroniser chain (>= 2)
  parameter int FILT_CNT    = 4,  // agreeing samples needed to accept a change (>= 1)
  parameter int CNT_W       = 3,  // filter counter width, must hold FILT_CNT-1
  parameter int DLY_CYC     = 8   // SCL_FILT -> SCL_DLY delay in cycles (>= 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic SCL_IN,
  input  logic SDA_IN,
  output logic SCL_FILT,
  output logic SDA_FILT,
  output logic SCL_RISE,
  output logic SCL_FALL,
  output logic START_DET,
  output logic STOP_DET,
  output logic BUS_BUSY,
  output logic SCL_DLY
);

  // Parameter sanity, evaluated at elaboration.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("i2c_in_filter: SYNC_STAGES must be at least 2");
  end
  if (FILT_CNT < 1) begin : g_chk_filt
    $error("i2c_in_filter: FILT_CNT must be at least 1");
  end
  if ((FILT_CNT - 1) >= (1 << CNT_W)) begin : g_chk_cnt_w
    $error("i2c_in_filter: CNT_W too narrow to hold FILT_CNT-1");
  end
  if (DLY_CYC < 1) begin : g_chk_dly
    $error("i2c_in_filter: DLY_CYC must be at least 1");
  end

  // Line index into the per-line vectors below.
  localparam int LN_SCL = 0;
  localparam int LN_SDA = 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CNT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_t;

  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_chain;
  logic [1:0]                  sync_lvl;
  logic [1:0][CNT_W-1:0]       filt_cnt;
  logic [1:0]                  filt;
  logic [1:0]                  filt_d;
  logic                        rise_c;
  logic                        fall_c;
  logic                        start_c;
  logic                        stop_c;
  bus_state_t                  state;
  bus_state_t                  state_nxt;
  logic [DLY_CYC-1:0]          dly;

  assign raw = {SDA_IN, SCL_IN};

  // Synchronisers: plain shift chains, idle-high after reset.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_chain <= '1;
    end else begin
      for (int l = 0; l < 2; l++) begin
        sync_chain[l] <= {sync_chain[l][SYNC_STAGES-2:0], raw[l]};
      end
    end
  end

  // Last synchroniser stage of each line feeds the filter.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      sync_lvl[l] = sync_chain[l][SYNC_STAGES-1];
    end
  end

  // Stability filter: accept a new level only after FILT_CNT disagreeing samples in a row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt     <= '1;
      filt_cnt <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (sync_lvl[l] == filt[l]) begin
          filt_cnt[l] <= '0;
        end else if (filt_cnt[l] == CNT_MAX) begin
          filt[l]     <= sync_lvl[l];
          filt_cnt[l] <= '0;
        end else begin
          filt_cnt[l] <= filt_cnt[l] + 1'b1;
        end
      end
    end
  end

  // Edge and bus-condition decode from the current and previous filtered levels.
  // START/STOP require SCL high on both sides, so a simultaneous SCL/SDA change is ignored.
  always_comb begin
    rise_c  = filt[LN_SCL] & ~filt_d[LN_SCL];
    fall_c  = ~filt[LN_SCL] & filt_d[LN_SCL];
    start_c = filt_d[LN_SCL] & filt[LN_SCL] & filt_d[LN_SDA] & ~filt[LN_SDA];
    stop_c  = filt_d[LN_SCL] & filt[LN_SCL] & ~filt_d[LN_SDA] & filt[LN_SDA];
  end

  // Previous-level registers and registered one-cycle strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_d    <= '1;
      SCL_RISE  <= 1'b0;
      SCL_FALL  <= 1'b0;
      START_DET <= 1'b0;
      STOP_DET  <= 1'b0;
    end else begin
      filt_d    <= filt;
      SCL_RISE  <= rise_c;
      SCL_FALL  <= fall_c;
      START_DET <= start_c;
      STOP_DET  <= stop_c;
    end
  end

  // Bus-busy state register; changes on the same edge the START/STOP strobe is registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus-busy next state: repeated START keeps BUSY, stray STOP keeps IDLE.
  // NOTE: the default is assigned first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start_c) state_nxt = ST_BUSY;
      ST_BUSY: if (stop_c)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Delay line for SCL_FILT; its output times SDA hold at the pad.
  // NOTE: this shift register is reset like any other state so SCL_DLY is a known idle-high level straight out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dly <= '1;
    end else begin
      dly[0] <= filt[LN_SCL];
      for (int i = 1; i < DLY_CYC; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign SCL_FILT = filt[LN_SCL];
  assign SDA_FILT = filt[LN_SDA];
  assign BUS_BUSY = (state == ST_BUSY);
  assign SCL_DLY  = dly[DLY_CYC-1];

endmodule

// File: tb/tb_i2c_in_filter.sv
// tb_i2c_in_filter: directed bus scenarios plus randomized glitchy pad traffic,
// every output checked each cycle against a history-based reference model.
module tb_i2c_in_filter;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_CNT    = 4;
  localparam int CNT_W       = 3;
  localparam int DLY_CYC     = 8;
  localparam int MAXC        = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_in = 1'b0;
  logic sda_in = 1'b0;
  logic scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy, scl_dly;

  i2c_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CNT   (FILT_CNT),
    .CNT_W      (CNT_W),
    .DLY_CYC    (DLY_CYC)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .SCL_IN   (scl_in),
    .SDA_IN   (sda_in),
    .SCL_FILT (scl_filt),
    .SDA_FILT (sda_filt),
    .SCL_RISE (scl_rise),
    .SCL_FALL (scl_fall),
    .START_DET(start_det),
    .STOP_DET (stop_det),
    .BUS_BUSY (bus_busy),
    .SCL_DLY  (scl_dly)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-edge histories indexed by edge number.
  int cyc      = 0;
  int last_rst = 0;
  bit raw_scl_h [MAXC];
  bit raw_sda_h [MAXC];
  bit sync_scl_h[MAXC];
  bit sync_sda_h[MAXC];
  bit f_scl_h   [MAXC];
  bit f_sda_h   [MAXC];
  bit e_rise, e_fall, e_start, e_stop, e_busy, e_dly;

  // Observed strobe totals, used by the directed scenarios.
  int obs_rise = 0, obs_fall = 0, obs_start = 0, obs_stop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // A filtered level flips once the last FILT_CNT synchronised samples since reset all differ from it.
  function automatic bit accept(input bit cur, input bit is_sda, input int n);
    bit ok;
    ok = (n - last_rst >= FILT_CNT);
    for (int k = 0; k < FILT_CNT; k++) begin
      if (ok && ((is_sda ? sync_sda_h[n-k] : sync_scl_h[n-k]) == cur)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic model_step();
    int n;
    bit s1, s2, d1, d2;
    cyc++;
    n = cyc;
    if (n >= MAXC) begin
      $display("FAIL model_capacity: got edge %0d, limit %0d", n, MAXC);
      $fatal(1);
    end
    raw_scl_h[n] = scl_in;
    raw_sda_h[n] = sda_in;
    if (rst) begin
      last_rst      = n;
      sync_scl_h[n] = 1'b1;
      sync_sda_h[n] = 1'b1;
      f_scl_h[n]    = 1'b1;
      f_sda_h[n]    = 1'b1;
      {e_rise, e_fall, e_start, e_stop, e_busy} = '0;
      e_dly = 1'b1;
    end else begin
      // Synchroniser output seen at this edge is the pad level SYNC_STAGES edges back.
      sync_scl_h[n] = (n - SYNC_STAGES > last_rst) ? raw_scl_h[n-SYNC_STAGES] : 1'b1;
      sync_sda_h[n] = (n - SYNC_STAGES > last_rst) ? raw_sda_h[n-SYNC_STAGES] : 1'b1;
      f_scl_h[n] = f_scl_h[n-1] ^ accept(f_scl_h[n-1], 1'b0, n);
      f_sda_h[n] = f_sda_h[n-1] ^ accept(f_sda_h[n-1], 1'b1, n);
      if (n >= last_rst + 2) begin
        s1 = f_scl_h[n-1]; s2 = f_scl_h[n-2];
        d1 = f_sda_h[n-1]; d2 = f_sda_h[n-2];
        e_rise  = s1 & ~s2;
        e_fall  = ~s1 & s2;
        e_start = s2 & s1 & d2 & ~d1;
        e_stop  = s2 & s1 & ~d2 & d1;
      end else begin
        {e_rise, e_fall, e_start, e_stop} = '0;
      end
      if (e_start)     e_busy = 1'b1;
      else if (e_stop) e_busy = 1'b0;
      e_dly = (n - DLY_CYC >= last_rst) ? f_scl_h[n-DLY_CYC] : 1'b1;
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("scl_filt",  scl_filt,  f_scl_h[cyc]);
    check("sda_filt",  sda_filt,  f_sda_h[cyc]);
    check("scl_rise",  scl_rise,  e_rise);
    check("scl_fall",  scl_fall,  e_fall);
    check("start_det", start_det, e_start);
    check("stop_det",  stop_det,  e_stop);
    check("bus_busy",  bus_busy,  e_busy);
    check("scl_dly",   scl_dly,   e_dly);
    obs_rise  += int'(scl_rise  === 1'b1);
    obs_fall  += int'(scl_fall  === 1'b1);
    obs_start += int'(start_det === 1'b1);
    obs_stop  += int'(stop_det  === 1'b1);
  endtask

  task automatic hold(input bit scl, input bit sda, input int n);
    scl_in = scl;
    sda_in = sda;
    repeat (n) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    int k, r0, f0, s0, p0;
    bit d, ns, nd;

    // Reset with both pads low: outputs must sit at idle-bus values.
    repeat (3) tick();
    check("rst_busy",  bus_busy,  1'b0);
    check("rst_scl",   scl_filt,  1'b1);
    check("rst_sda",   sda_filt,  1'b1);
    check("rst_dly",   scl_dly,   1'b1);
    check("rst_start", start_det, 1'b0);

    // Release: SCL_FILT must fall SYNC_STAGES+FILT_CNT edges later.
    rst = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (scl_filt === 1'b1 && k < 50);
    check("release_latency", k, SYNC_STAGES + FILT_CNT);
    hold(1'b1, 1'b1, 30);

    // Glitch rejection: FILT_CNT-1 low cycles are discarded.
    s0 = obs_start;
    hold(1'b1, 1'b0, FILT_CNT - 1);
    hold(1'b1, 1'b1, 20);
    check("glitch_start", obs_start - s0, 0);
    check("glitch_sda",   sda_filt, 1'b1);

    // FILT_CNT low cycles are accepted and make a START.
    hold(1'b1, 1'b0, FILT_CNT);
    hold(1'b1, 1'b0, 20);
    check("start_count", obs_start - s0, 1);
    check("start_busy",  bus_busy, 1'b1);

    // Nine clock pulses with data changing only while SCL is low.
    r0 = obs_rise; f0 = obs_fall; s0 = obs_start; p0 = obs_stop;
    d = 1'b0;
    for (int i = 0; i < 9; i++) begin
      hold(1'b0, d, 10);
      d = (i == 8) ? 1'b0 : 1'($urandom_range(0, 1));
      hold(1'b0, d, 10);
      hold(1'b1, d, 20);
    end
    check("byte_rise",  obs_rise - r0, 9);
    check("byte_fall",  obs_fall - f0, 9);
    check("byte_start", obs_start - s0, 0);
    check("byte_stop",  obs_stop - p0, 0);

    // Repeated START while busy.
    s0 = obs_start;
    hold(1'b0, 1'b0, 20);
    hold(1'b0, 1'b1, 20);
    hold(1'b1, 1'b1, 20);
    hold(1'b1, 1'b0, 20);
    check("rstart_count", obs_start - s0, 1);
    check("rstart_busy",  bus_busy, 1'b1);

    // STOP.
    p0 = obs_stop;
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    check("stop_count", obs_stop - p0, 1);
    check("stop_busy",  bus_busy, 1'b0);

    // Simultaneous SCL and SDA rise while busy: only SCL_RISE.
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);
    r0 = obs_rise; p0 = obs_stop;
    hold(1'b1, 1'b1, 20);
    check("simul_rise", obs_rise - r0, 1);
    check("simul_stop", obs_stop - p0, 0);
    check("simul_busy", bus_busy, 1'b1);

    // Reset mid-transfer with SCL low, then idle-high pads.
    hold(1'b0, 1'b1, 20);
    check("pre_rst_busy", bus_busy, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", bus_busy, 1'b0);
    rst = 1'b0;
    s0 = obs_start; p0 = obs_stop;
    hold(1'b1, 1'b1, 40);
    check("post_rst_start", obs_start - s0, 0);
    check("post_rst_stop",  obs_stop - p0, 0);

    // Randomized traffic: short and long pulses around the filter length, occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end
      ns = scl_in;
      nd = sda_in;
      case ($urandom_range(0, 3))
        0: ns = ~ns;
        1: nd = ~nd;
        2: begin ns = ~ns; nd = ~nd; end
        default: ;
      endcase
      hold(ns, nd, $urandom_range(1, 3 * FILT_CNT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
